change_dispenser: RTL and testbench
===================================

// Module: change_dispenser
// PURPOSE
//  Consumer side of the vending machine's change interface: accepts a change amount (in nickel
//  units) from the vending FSM and pays it out coin-by-coin to the coin ejector mechanism.
//  Greedy largest-coin-first, with per-denomination stock tracking and refill inputs.
//  Sits between the vending controller and the ejector solenoid driver.
// PARAMETERS
//  AW=5           amount width, units of 5c (max 155c)
//  CW=6           stock counter width per denomination
//  INIT_N=20      nickel stock after reset
//  INIT_D=20      dime stock after reset
//  INIT_Q=8       quarter stock after reset (used only with CHANGE_QUARTER_EN)
//  ACK_TIMEOUT=15 max cycles in EJECT without eject_ack before FAULT
// PORTS
//  clk        in  1   clock, rising edge
//  reset      in  1   asynchronous, active-low reset
//  req        in  1   change request strobe, sampled only when ready=1
//  amt        in  AW  change amount in nickel units, sampled with req
//  ready      out 1   dispenser idle, can accept req
//  eject      out 2   coin command: 00 none, 01 nickel, 10 dime, 11 quarter
//  eject_ack  in  1   ejector confirms the commanded coin left
//  done       out 1   1-cycle pulse: full amount paid
//  fault      out 1   sticky: payout aborted (no coin fits, or ack timeout)
//  shortfall  out AW  unpaid remainder, valid while fault=1, else 0
//  clr        in  1   clears fault, returns to IDLE
//  refill_n/refill_d/refill_q in 1 each   +1 coin to that stock per cycle high
//  stock_n/stock_d/stock_q    out CW each current stock counts
// BEHAVIOUR
//  Reset (reset=0, async): state IDLE, ready=1, eject=00, done=0, fault=0, shortfall=0,
//   stocks=INIT_*; reset mid-payout abandons it, no done/fault.
//  States: IDLE, SELECT, EJECT, DONE, FAULT.
//  IDLE: req&ready latches amt into rem -> SELECT; ready=0 next cycle. req while ready=0 ignored.
//  SELECT (1 cycle): Q if rem>=5 & stock_q>0; else D if rem>=2 & stock_d>0; else N if rem>=1 &
//   stock_n>0 -> EJECT with code. rem==0 -> DONE. rem>0 & nothing fits -> FAULT.
//  EJECT: eject held at code, timer counts. eject_ack=1 sampled -> stock-=1, rem-=coin value,
//   eject=00 next cycle, -> SELECT. Timer reaching ACK_TIMEOUT w/o ack -> FAULT, stock/rem unchanged.
//  Latency: req to first eject = 2 cycles; each coin = ack cycle + 1 SELECT cycle.
//  DONE: done=1 one cycle -> IDLE. amt=0 gives done 2 cycles after req, no eject.
//  FAULT: fault=1, shortfall=rem, eject=00; stays until clr=1 -> IDLE (fault, shortfall cleared).
//  Stocks saturate at 2^CW-1 on refill, never go below 0; refill and ack-decrement of the same
//   denomination in one cycle -> count unchanged. Refill honoured in every state.
//  eject_ack outside EJECT ignored.
// CONFIGURATION
//  CHANGE_QUARTER_EN defined: quarters dispensed per SELECT rule, stock_q tracked from INIT_Q.
//  Not defined: code 11 never issued, refill_q ignored, stock_q tied to 0; ports unchanged.
// STRUCTURE
//  Package vm_change_pkg: coin codes (COIN_NONE/N/D/Q), coin values (1/2/5), state enum.
//  Sub-module coin_stock_counter: saturating CW-bit up/down counter with INIT parameter,
//   one instance per denomination.
// TESTING
//  1 defaults, amt=3 -> eject 10, ack, eject 01, ack, done pulse; stock_d=19, stock_n=19.
//  2 amt=7 -> with CHANGE_QUARTER_EN: 11,10 then done; without: 10,10,10,01 then done.
//  3 INIT_D=0, amt=2 -> 01,01, done; INIT_N=0,INIT_D=0, amt=1 -> fault=1, shortfall=1;
//    clr -> ready=1, fault=0.
//  4 no eject_ack for 15 cycles in EJECT, amt=4 -> fault=1, shortfall=4, stocks unchanged.
//  5 refill_d high in same cycle as dime ack -> stock_d unchanged; 70 refill_n pulses
//    -> stock_n=63.
//  6 reset low during EJECT -> eject=00 immediately; after release ready=1, stocks=INIT.

Source files
------------

// File: rtl/vm_change_pkg.sv
// Shared definitions for the change dispenser: coin codes, coin values in nickel units,
// and the payout FSM state encoding.
package vm_change_pkg;

  typedef enum logic [1:0] {
    COIN_NONE = 2'b00,
    COIN_N    = 2'b01,
    COIN_D    = 2'b10,
    COIN_Q    = 2'b11
  } coin_e;

  localparam int VAL_N = 1;
  localparam int VAL_D = 2;
  localparam int VAL_Q = 5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_EJECT,
    ST_DONE,
    ST_FAULT
  } state_e;

  function automatic int unsigned coin_value(input coin_e c);
    case (c)
      COIN_N:  return VAL_N;
      COIN_D:  return VAL_D;
      COIN_Q:  return VAL_Q;
      default: return 0;
    endcase
  endfunction

endpackage

// File: rtl/coin_stock_counter.sv
// Per-denomination coin stock: saturating up/down counter, loads INIT on reset.
// Simultaneous increment and decrement cancel out.
module coin_stock_counter #(
  parameter int CW   = 6,
  parameter int INIT = 20
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_inc,
  input  logic          i_dec,
  output logic [CW-1:0] o_count
);

  logic [CW-1:0] r_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= CW'(INIT);
    end else if (i_inc && !i_dec) begin
      if (r_count != '1) r_count <= r_count + CW'(1);
    end else if (i_dec && !i_inc) begin
      if (r_count != '0) r_count <= r_count - CW'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/change_dispenser.sv
// Change dispenser: pays a nickel-unit amount coin-by-coin, largest coin first, with stock
// tracking. Define CHANGE_QUARTER_EN to enable quarter payout and quarter stock.
module change_dispenser
  import vm_change_pkg::*;
#(
  parameter int AW          = 5,
  parameter int CW          = 6,
  parameter int INIT_N      = 20,
  parameter int INIT_D      = 20,
  parameter int INIT_Q      = 8,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req,
  input  logic [AW-1:0] amt,
  output logic          ready,
  output logic [1:0]    eject,
  input  logic          eject_ack,
  output logic          done,
  output logic          fault,
  output logic [AW-1:0] shortfall,
  input  logic          clr,
  input  logic          refill_n,
  input  logic          refill_d,
  input  logic          refill_q,
  output logic [CW-1:0] stock_n,
  output logic [CW-1:0] stock_d,
  output logic [CW-1:0] stock_q
);

`ifdef CHANGE_QUARTER_EN
  localparam bit Q_EN = 1'b1;
`else
  localparam bit Q_EN = 1'b0;
`endif
  localparam int TW = $clog2(ACK_TIMEOUT + 1);

  state_e        r_state, w_state_nxt;
  coin_e         r_code, w_code_nxt;
  logic [TW-1:0] r_timer, w_timer_nxt;
  logic [AW-1:0] r_rem, w_rem_nxt;
  logic          w_ack;

  assign w_ack = (r_state == ST_EJECT) && eject_ack;

  coin_stock_counter #(.CW(CW), .INIT(INIT_N)) u_stock_n (
    .i_clk(clk), .i_rst_n(reset), .i_inc(refill_n),
    .i_dec(w_ack && (r_code == COIN_N)), .o_count(stock_n));

  coin_stock_counter #(.CW(CW), .INIT(INIT_D)) u_stock_d (
    .i_clk(clk), .i_rst_n(reset), .i_inc(refill_d),
    .i_dec(w_ack && (r_code == COIN_D)), .o_count(stock_d));

  // Without quarters this counter resets to 0 and never moves.
  coin_stock_counter #(.CW(CW), .INIT(Q_EN ? INIT_Q : 0)) u_stock_q (
    .i_clk(clk), .i_rst_n(reset), .i_inc(refill_q && Q_EN),
    .i_dec(w_ack && (r_code == COIN_Q)), .o_count(stock_q));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_code  <= COIN_NONE;
      r_timer <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_code  <= w_code_nxt;
      r_timer <= w_timer_nxt;
    end
  end

  // Remainder is only observed in SELECT/EJECT/FAULT, all entered after a load from amt.
  always_ff @(posedge clk) begin
    r_rem <= w_rem_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_code_nxt  = r_code;
    w_timer_nxt = r_timer;
    w_rem_nxt   = r_rem;
    ready       = 1'b0;
    eject       = COIN_NONE;
    done        = 1'b0;
    fault       = 1'b0;
    shortfall   = '0;
    case (r_state)
      ST_IDLE: begin
        ready = 1'b1;
        if (req) begin
          w_rem_nxt   = amt;
          w_state_nxt = ST_SELECT;
        end
      end
      ST_SELECT: begin
        w_timer_nxt = '0;
        if (r_rem == '0) begin
          w_state_nxt = ST_DONE;
        end else if (Q_EN && (r_rem >= AW'(VAL_Q)) && (stock_q != '0)) begin
          w_code_nxt  = COIN_Q;
          w_state_nxt = ST_EJECT;
        end else if ((r_rem >= AW'(VAL_D)) && (stock_d != '0)) begin
          w_code_nxt  = COIN_D;
          w_state_nxt = ST_EJECT;
        end else if (stock_n != '0) begin
          w_code_nxt  = COIN_N;
          w_state_nxt = ST_EJECT;
        end else begin
          w_state_nxt = ST_FAULT;
        end
      end
      ST_EJECT: begin
        eject = r_code;
        if (eject_ack) begin
          w_rem_nxt   = r_rem - AW'(coin_value(r_code));
          w_state_nxt = ST_SELECT;
        end else if (r_timer == TW'(ACK_TIMEOUT - 1)) begin
          w_state_nxt = ST_FAULT;
        end else begin
          w_timer_nxt = r_timer + TW'(1);
        end
      end
      ST_DONE: begin
        done        = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      ST_FAULT: begin
        fault     = 1'b1;
        shortfall = r_rem;
        if (clr) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_change_dispenser.sv
// Randomized self-checking bench for change_dispenser with a coin-level reference model.
module tb_change_dispenser;

`ifdef CHANGE_QUARTER_EN
  localparam int QEN = 1;
`else
  localparam int QEN = 0;
`endif
  localparam int SMAX = 63;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // main instance (default parameters)
  logic       req, eject_ack, clr, refill_n, refill_d, refill_q;
  logic [4:0] amt;
  logic       ready, done, fault;
  logic [1:0] eject;
  logic [4:0] shortfall;
  logic [5:0] stock_n, stock_d, stock_q;

  change_dispenser dut (
    .clk(clk), .reset(rst_n), .req(req), .amt(amt), .ready(ready), .eject(eject),
    .eject_ack(eject_ack), .done(done), .fault(fault), .shortfall(shortfall), .clr(clr),
    .refill_n(refill_n), .refill_d(refill_d), .refill_q(refill_q),
    .stock_n(stock_n), .stock_d(stock_d), .stock_q(stock_q));

  // low-stock instances share one stimulus set
  logic       x_req, x_ack, x_clr;
  logic [4:0] x_amt;
  logic       a_ready, a_done, a_fault, b_ready, b_done, b_fault;
  logic [1:0] a_eject, b_eject;
  logic [4:0] a_short, b_short;
  logic [5:0] a_sn, a_sd, a_sq, b_sn, b_sd, b_sq;

  change_dispenser #(.INIT_D(0)) dut_d0 (
    .clk(clk), .reset(rst_n), .req(x_req), .amt(x_amt), .ready(a_ready), .eject(a_eject),
    .eject_ack(x_ack), .done(a_done), .fault(a_fault), .shortfall(a_short), .clr(x_clr),
    .refill_n(1'b0), .refill_d(1'b0), .refill_q(1'b0),
    .stock_n(a_sn), .stock_d(a_sd), .stock_q(a_sq));

  change_dispenser #(.INIT_N(0), .INIT_D(0)) dut_empty (
    .clk(clk), .reset(rst_n), .req(x_req), .amt(x_amt), .ready(b_ready), .eject(b_eject),
    .eject_ack(x_ack), .done(b_done), .fault(b_fault), .shortfall(b_short), .clr(x_clr),
    .refill_n(1'b0), .refill_d(1'b0), .refill_q(1'b0),
    .stock_n(b_sn), .stock_d(b_sd), .stock_q(b_sq));

  int n_tests = 0;
  int n_fail  = 0;
  int m_stock [3];            // model stock: 0 nickel, 1 dime, 2 quarter
  int coin_val [4] = '{0, 1, 2, 5};

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Greedy choice from the payout rule; returns coin code 1..3 or 0 if nothing fits.
  function automatic int pick(input int rem);
    if (QEN == 1 && rem >= 5 && m_stock[2] > 0) return 3;
    if (rem >= 2 && m_stock[1] > 0) return 2;
    if (rem >= 1 && m_stock[0] > 0) return 1;
    return 0;
  endfunction

  task automatic model_reset();
    m_stock[0] = 20;
    m_stock[1] = 20;
    m_stock[2] = (QEN == 1) ? 8 : 0;
  endtask

  task automatic check_stocks(input string tag);
    check_val({tag, "_sn"}, stock_n, m_stock[0]);
    check_val({tag, "_sd"}, stock_d, m_stock[1]);
    check_val({tag, "_sq"}, stock_q, m_stock[2]);
  endtask

  task automatic clear_fault();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check_val("clr_ready", ready, 1);
    check_val("clr_fault", fault, 0);
    check_val("clr_short", shortfall, 0);
  endtask

  task automatic refill(input int which, input int cyc);
    for (int i = 0; i < cyc; i++) begin
      refill_n = (which == 0);
      refill_d = (which == 1);
      refill_q = (which == 2);
      @(negedge clk);
      if ((which != 2 || QEN == 1) && m_stock[which] < SMAX) m_stock[which]++;
    end
    refill_n = 1'b0;
    refill_d = 1'b0;
    refill_q = 1'b0;
  endtask

  // mode: 0 random ack delay with rare timeout, 1 force timeout on first coin.
  // refill_same: raise the refill of the ejected denomination during every ack.
  task automatic run_txn(input int a, input int mode, input int refill_same);
    int rem, c;
    check_val("txn_ready", ready, 1);
    req = 1'b1;
    amt = 5'(a);
    @(negedge clk);
    req = 1'b0;
    rem = a;
    for (int k = 0; k < 40; k++) begin
      c = pick(rem);
      @(negedge clk);
      check_val("busy", ready, 0);
      if (rem == 0) begin
        check_val("done", done, 1);
        check_val("done_eject", eject, 0);
        @(negedge clk);
        check_val("done_pulse", done, 0);
        check_val("done_ready", ready, 1);
        return;
      end
      if (c == 0) begin
        check_val("nofit_fault", fault, 1);
        check_val("nofit_short", shortfall, rem);
        check_val("nofit_eject", eject, 0);
        clear_fault();
        return;
      end
      check_val("eject_code", eject, c);
      if ((mode == 1 && k == 0) || (mode == 0 && $urandom_range(0, 31) == 0)) begin
        repeat (14) @(negedge clk);
        check_val("to_hold", eject, c);
        check_val("to_early", fault, 0);
        @(negedge clk);
        check_val("to_fault", fault, 1);
        check_val("to_short", shortfall, rem);
        check_val("to_eject", eject, 0);
        check_stocks("to");
        clear_fault();
        return;
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
      check_val("eject_hold", eject, c);
      eject_ack = 1'b1;
      if (refill_same != 0) begin
        refill_n = (c == 1);
        refill_d = (c == 2);
        refill_q = (c == 3);
      end
      @(negedge clk);
      eject_ack = 1'b0;
      refill_n = 1'b0;
      refill_d = 1'b0;
      refill_q = 1'b0;
      if (refill_same == 0) m_stock[c-1]--;
      rem -= coin_val[c];
      check_val("ack_eject_off", eject, 0);
      check_stocks("ack");
    end
    check_val("txn_bound", 0, 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    {req, eject_ack, clr, refill_n, refill_d, refill_q} = '0;
    amt = '0;
    {x_req, x_ack, x_clr} = '0;
    x_amt = '0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    check_val("rst_ready", ready, 1);
    check_val("rst_eject", eject, 0);
    check_val("rst_done", done, 0);
    check_val("rst_fault", fault, 0);
    check_val("rst_short", shortfall, 0);
    check_stocks("rst");

    run_txn(3, 2, 0);
    check_val("t1_sd", stock_d, 19);
    check_val("t1_sn", stock_n, 19);
    run_txn(7, 2, 0);
    run_txn(2, 2, 1);
    refill(0, 70);
    check_val("t5_sat", stock_n, 63);
    run_txn(4, 1, 0);

    // low-stock instances
    x_req = 1'b1; x_amt = 5'd2;
    @(negedge clk);
    x_req = 1'b0;
    @(negedge clk);
    check_val("d0_coin1", a_eject, 1);
    check_val("empty_fault", b_fault, 1);
    check_val("empty_short2", b_short, 2);
    x_ack = 1'b1; @(negedge clk); x_ack = 1'b0;
    @(negedge clk);
    check_val("d0_coin2", a_eject, 1);
    x_ack = 1'b1; @(negedge clk); x_ack = 1'b0;
    @(negedge clk);
    check_val("d0_done", a_done, 1);
    check_val("d0_sn", a_sn, 18);
    check_val("d0_sd", a_sd, 0);
    x_clr = 1'b1; @(negedge clk); x_clr = 1'b0;
    check_val("empty_clr_ready", b_ready, 1);
    check_val("empty_clr_fault", b_fault, 0);
    check_val("empty_clr_short", b_short, 0);
    x_req = 1'b1; x_amt = 5'd1;
    @(negedge clk);
    x_req = 1'b0;
    @(negedge clk);
    check_val("empty_fault1", b_fault, 1);
    check_val("empty_short1", b_short, 1);
    check_val("d0_nickel", a_eject, 1);
    x_ack = 1'b1; @(negedge clk); x_ack = 1'b0;
    repeat (2) @(negedge clk);
    x_clr = 1'b1; @(negedge clk); x_clr = 1'b0;
    check_val("empty_ready2", b_ready, 1);
    check_val("empty_fault2", b_fault, 0);

    // reset in the middle of a payout
    model_reset();
    req = 1'b1; amt = 5'd3;
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    check_val("r6_eject_on", eject, 2);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("r6_eject_off", eject, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_val("r6_ready", ready, 1);
    check_val("r6_done", done, 0);
    check_val("r6_fault", fault, 0);
    check_stocks("r6");

    for (int t = 0; t < 40; t++) begin
      for (int w = 0; w < 3; w++) refill(w, $urandom_range(0, 6));
      if ($urandom_range(0, 3) == 0) begin
        eject_ack = 1'b1;
        @(negedge clk);
        eject_ack = 1'b0;
      end
      run_txn($urandom_range(0, 31), 0, 0);
    end
    check_stocks("final");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
